alu_74181_serial: RTL and testbench

Parametrised, nibble-serial successor to the two-slice 74181 datapath. It computes the full 74181 function set (16 logic and 16 arithmetic modes) on WIDTH-bit operands using a single 4-bit 74181 slice, one nibble per enabled clock, LSB nibble first. The carry is chained through a register between nibbles. The block adds a start/busy/done handshake, synchronous abort and an accumulate mode (previous result fed back as A). It sits behind the SPI register file: config registers drive its inputs and status registers capture its outputs.

---
 rtl/alu_74181_serial_if.sv | 34 +++
 rtl/alu_74181_serial.sv | 181 ++++++++++++++++++
 tb/tb_alu_74181_serial.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_74181_serial_if.sv
// rtl/alu_74181_serial_if.sv - Control, operand and status bundle for the nibble-serial 74181 ALU
interface alu_74181_serial_if #(
  parameter int WIDTH = 16
);
  // Control and operands, driven by the register file
  logic             ena;
  logic             start;
  logic             clear;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cn;

  // Status and result, captured by the register file
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             equal;
  logic             p;
  logic             g;

  modport master (
    output ena, start, clear, acc, a, b, s, m, cn,
    input  busy, done, f, cout, equal, p, g
  );

  modport slave (
    input  ena, start, clear, acc, a, b, s, m, cn,
    output busy, done, f, cout, equal, p, g
  );
endinterface

// File: rtl/alu_74181_serial.sv
// rtl/alu_74181_serial.sv - WIDTH-bit 74181 ALU built from one 4-bit slice, one nibble per enabled clock
module alu_74181_serial #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rstb,
  alu_74181_serial_if.slave  bus
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;

  // Operands latched at start so the inputs may change during RUN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;      // inter-nibble carry, active-low like the pin
  logic [IDX_W-1:0] idx_q;
  logic             ph_q;         // running group propagate, active-high
  logic             gh_q;         // running group generate, active-high
  logic [WIDTH-1:0] res_q, res_d;

  // Published results, updated only at completion
  logic [WIDTH-1:0] f_q;
  logic             cout_q;
  logic             equal_q;
  logic             p_q;
  logic             g_q;
  logic             done_q;

  // Control strobes
  logic             latch_en;
  logic             step_en;
  logic             finish;
  logic             last_nib;

  // Slice signals
  logic [3:0]       nib_a, nib_b;
  logic [3:0]       x, y;
  logic [3:0]       c;
  logic [3:0]       nib_f;
  logic             ph_k, gh_k, cn4;
  logic             ph_d, gh_d;

  assign last_nib = (idx_q == IDX_W'(NIB - 1));

  // 74181 slice on the current nibble; x/y are the per-bit propagate/generate terms
  always_comb begin
    nib_a = a_q[4*int'(idx_q) +: 4];
    nib_b = b_q[4*int'(idx_q) +: 4];
    x     = nib_a | (nib_b & {4{s_q[0]}}) | (~nib_b & {4{s_q[1]}});
    y     = (nib_a & nib_b & {4{s_q[3]}}) | (nib_a & ~nib_b & {4{s_q[2]}});
    c     = '0;
    c[0]  = ~carry_q;
    for (int i = 0; i < 3; i++) begin
      c[i+1] = y[i] | (x[i] & c[i]);
    end
    nib_f = m_q ? ~(x ^ y) : (x ^ y ^ c);
    ph_k  = &x;
    gh_k  = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);
    // Cn+4 comes from the lookahead terms, so it is valid in logic mode too
    cn4   = ~(gh_k | (ph_k & c[0]));
    gh_d  = gh_k | (ph_k & gh_q);
    ph_d  = ph_q & ph_k;
    res_d = res_q;
    res_d[4*int'(idx_q) +: 4] = nib_f;
  end

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear wins over start and completion
  always_comb begin
    state_d = state_q;
    if (bus.ena) begin
      if (bus.clear) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (bus.start) state_d = ST_RUN;
          ST_RUN:  if (last_nib)  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Output decode: strobes for the datapath and the busy flag
  always_comb begin
    latch_en = 1'b0;
    step_en  = 1'b0;
    finish   = 1'b0;
    bus.busy = (state_q == ST_RUN);
    if (bus.ena && !bus.clear) begin
      if (state_q == ST_IDLE) begin
        latch_en = bus.start;
      end else begin
        step_en = 1'b1;
        finish  = last_nib;
      end
    end
  end

  // Operand capture at start, then per-nibble carry/group/result update
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      ph_q    <= 1'b0;
      gh_q    <= 1'b0;
      res_q   <= '0;
    end else if (latch_en) begin
      a_q     <= bus.acc ? f_q : bus.a;
      b_q     <= bus.b;
      s_q     <= bus.s;
      m_q     <= bus.m;
      carry_q <= bus.cn;
      idx_q   <= '0;
      ph_q    <= 1'b1;
      gh_q    <= 1'b0;
    end else if (step_en) begin
      res_q   <= res_d;
      carry_q <= cn4;
      ph_q    <= ph_d;
      gh_q    <= gh_d;
      idx_q   <= last_nib ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Publish results on the final nibble only
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      f_q     <= '0;
      cout_q  <= 1'b1;
      equal_q <= 1'b0;
      p_q     <= 1'b1;
      g_q     <= 1'b1;
    end else if (finish) begin
      f_q     <= res_d;
      cout_q  <= cn4;
      equal_q <= &res_d;
      p_q     <= ~ph_d;
      g_q     <= ~gh_d;
    end
  end

  // Done pulse, held while ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      done_q <= 1'b0;
    end else if (bus.ena) begin
      done_q <= finish;
    end
  end

  assign bus.done  = done_q;
  assign bus.f     = f_q;
  assign bus.cout  = cout_q;
  assign bus.equal = equal_q;
  assign bus.p     = p_q;
  assign bus.g     = g_q;

endmodule

// File: tb/tb_alu_74181_serial.sv
// tb/tb_alu_74181_serial.sv - Self-checking bench for alu_74181_serial
module tb_alu_74181_serial;

  localparam int NIB = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  alu_74181_serial_if #(.WIDTH(16)) bus ();
  alu_74181_serial_if #(.WIDTH(8))  bus8 ();

  alu_74181_serial #(.WIDTH(16)) dut  (.clk(clk), .rstb(rstb), .bus(bus));
  alu_74181_serial #(.WIDTH(8))  dut8 (.clk(clk), .rstb(rstb), .bus(bus8));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word-level reference: the 74181 adds its OR-term word to its AND-term word
  function automatic logic [19:0] ref_op(input logic [15:0] aa, input logic [15:0] bb,
                                         input logic [3:0] ss, input logic mm, input logic ccn);
    logic [15:0] xw, yw, fw;
    logic [16:0] sum, gsum;
    xw   = aa | (bb & {16{ss[0]}}) | (~bb & {16{ss[1]}});
    yw   = (aa & bb & {16{ss[3]}}) | (aa & ~bb & {16{ss[2]}});
    sum  = {1'b0, xw} + {1'b0, yw} + {16'd0, ~ccn};
    gsum = {1'b0, xw} + {1'b0, yw};
    fw   = mm ? ~(xw ^ yw) : sum[15:0];
    return {fw, ~sum[16], &fw, ~(&xw), ~gsum[16]};
  endfunction

  // Transaction-level model of the 16-bit instance
  logic        mbusy = 1'b0, mdone = 1'b0, mcout = 1'b1, meq = 1'b0, mp = 1'b1, mg = 1'b1;
  logic [15:0] mf = 16'h0;
  logic [19:0] pend = 20'h0;
  int          left = 0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mbusy = 1'b0; mdone = 1'b0; mf = 16'h0; mcout = 1'b1; meq = 1'b0; mp = 1'b1; mg = 1'b1;
      left  = 0;
    end else if (bus.ena) begin
      if (bus.clear) begin
        mbusy = 1'b0;
        mdone = 1'b0;
      end else if (mbusy) begin
        left--;
        if (left == 0) begin
          {mf, mcout, meq, mp, mg} = pend;
          mbusy = 1'b0;
          mdone = 1'b1;
        end
      end else begin
        mdone = 1'b0;
        if (bus.start) begin
          pend  = ref_op(bus.acc ? mf : bus.a, bus.b, bus.s, bus.m, bus.cn);
          mbusy = 1'b1;
          left  = NIB;
        end
      end
    end
  end

  // Compare every cycle out of reset
  always @(negedge clk) begin
    if (rstb) begin
      chk("cycle", {bus.busy, bus.done, bus.f, bus.cout, bus.equal, bus.p, bus.g},
          {mbusy, mdone, mf, mcout, meq, mp, mg});
    end
  end

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is,
                        input logic im, input logic icn, input logic iacc,
                        input int start_at, input int clear_at, input int ena_at, input int rst_at,
                        output int lat, output int ndone, output int dhigh);
    logic prev;
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.s = is; bus.m = im; bus.cn = icn; bus.acc = iacc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; ndone = 0; dhigh = 0; prev = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin
        dhigh++;
        if (!prev) ndone++;
        if (lat < 0) lat = k;
      end
      prev      = bus.done;
      bus.start = (k == start_at);
      bus.clear = (k == clear_at);
      bus.ena   = !(ena_at >= 0 && k >= ena_at && k < ena_at + 3);
      if (k == rst_at) begin
        #1 rstb = 1'b0;
        #2;
        chk("midrun_reset_outputs",
            {bus.busy, bus.done, bus.f, bus.cout, bus.equal, bus.p, bus.g},
            {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});
        rstb = 1'b1;
      end
    end
    bus.start = 1'b0; bus.clear = 1'b0; bus.ena = 1'b1; bus.acc = 1'b0;
  endtask

  int lat, nd, dh, cyc;

  initial begin
    bus.ena = 1'b1; bus.start = 1'b0; bus.clear = 1'b0; bus.acc = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cn = 1'b1;
    bus8.ena = 1'b1; bus8.start = 1'b0; bus8.clear = 1'b0; bus8.acc = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.s = '0; bus8.m = 1'b0; bus8.cn = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_state", {bus.busy, bus.done, bus.f, bus.cout, bus.equal, bus.p, bus.g},
        {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});
    rstb = 1'b1;

    // Add
    run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, -1, -1, lat, nd, dh);
    chk("add_latency", lat, 4);
    chk("add_f", bus.f, 16'h2345);
    chk("add_cout_eq", {bus.cout, bus.equal}, 2'b10);
    chk("add_one_done", {nd, dh}, {32'd1, 32'd1});

    // Carry ripples through every nibble
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, -1, -1, lat, nd, dh);
    chk("wrap_f_cout", {bus.f, bus.cout}, {16'h0000, 1'b0});

    // Subtract with carry-in
    run_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1, lat, nd, dh);
    chk("sub_f_cout", {bus.f, bus.cout}, {16'h4FFF, 1'b0});

    // Compare equal operands
    run_op(16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b1, 1'b0, -1, -1, -1, -1, lat, nd, dh);
    chk("cmp_f_equal", {bus.f, bus.equal}, {16'hFFFF, 1'b1});

    // Logic XOR with a stray start mid-RUN
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b0, 2, -1, -1, -1, lat, nd, dh);
    chk("xor_f", bus.f, 16'h0FF0);
    chk("xor_single_done", nd, 1);

    // Accumulate back-to-back from f=0
    @(negedge clk); rstb = 1'b0;
    @(negedge clk); rstb = 1'b1;
    bus.acc = 1'b1; bus.s = 4'b1001; bus.m = 1'b0; bus.cn = 1'b1; bus.b = 16'h0001;
    bus.a = 16'hDEAD; bus.start = 1'b1;
    nd = 0; cyc = 0;
    while (nd < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        nd++;
        if (nd == 5) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0; bus.acc = 1'b0;
    chk("acc_f", bus.f, 16'h0005);
    chk("acc_cycles", cyc, 25);

    // Reload without accumulate
    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, -1, -1, lat, nd, dh);
    chk("reload_f", bus.f, 16'h0100);

    // Clear at nibble 2: no done, result held
    run_op(16'h1111, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0, -1, 2, -1, -1, lat, nd, dh);
    chk("clear_no_done", nd, 0);
    chk("clear_f_held", bus.f, 16'h0100);

    // ena low three cycles mid-RUN
    run_op(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, 2, -1, lat, nd, dh);
    chk("ena_latency", lat, 7);
    chk("ena_f", bus.f, 16'h0003);

    // ena low in the done cycle stretches done
    run_op(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, 4, -1, lat, nd, dh);
    chk("stretch_latency", lat, 4);
    chk("stretch_done_cycles", dh, 4);
    chk("stretch_f", bus.f, 16'h0007);

    // Reset mid-RUN
    run_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0, -1, -1, -1, 2, lat, nd, dh);
    chk("reset_no_done", nd, 0);
    chk("reset_f", bus.f, 16'h0000);

    // 8-bit instance add
    @(negedge clk);
    bus8.a = 8'h34; bus8.b = 8'h11; bus8.s = 4'b1001; bus8.m = 1'b0; bus8.cn = 1'b1;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w8_latency", lat, 2);
    chk("w8_f_cout", {bus8.f, bus8.cout}, {8'h45, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
